mem_refill_responder: RTL and testbench

- Memory-side responder for the cache controller's refill interface.
- Accepts a line request (req_cc2mem, adr_cc2mem) from the controller and answers after a fixed latency with a 4-beat burst: ack_mem2cc high for 4 consecutive cycles, dat_mem2cc carrying words 0..3 of the 16-byte line.
- Backed by an internal word RAM.
- Includes a side-band preload port so benches and boot logic can fill memory contents.

---
 rtl/mem_refill_responder.sv | 125 ++++++++++++
 tb/tb_mem_refill_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_refill_responder.sv
// Memory-side refill responder: accepts a line request, waits LATENCY cycles,
// then returns the line as a registered 4-beat burst read from an internal word RAM.
module mem_refill_responder #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2,
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc2mem,
    input  logic [ADR_WIDTH-1:0]  adr_cc2mem,
    output logic                  ack_mem2cc,
    output logic [DATA_WIDTH-1:0] dat_mem2cc,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_adr,
    input  logic [DATA_WIDTH-1:0] init_dat,
    output logic                  busy
);

    localparam int LINE_W = DEPTH_LOG2 - WORD_OFFSET;
    localparam int LAT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [WORD_OFFSET-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    ack_d;
    logic                    ack_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DEPTH_LOG2-1:0]   rd_adr;
    logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    // Byte/word-offset bits and bits above the RAM range are intentionally ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:DEPTH_LOG2+2], adr_cc2mem[WORD_OFFSET+1:0]};

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_cc2mem) begin
                    line_d = adr_cc2mem[DEPTH_LOG2+1:WORD_OFFSET+2];
                    beat_d = '0;
                    if (LATENCY == 0) begin
                        state_d = S_BURST;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = LAT_W'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                if (!req_cc2mem) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        state_d = S_BURST;
                    end
                end
            end
            S_BURST: begin
                // Beat counter wraps back to 0 as the last beat leaves.
                ack_d  = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == '1) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!req_cc2mem) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_adr = {line_q, beat_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            ack_q   <= ack_d;
            // Synchronous read lands in the output register together with its ack.
            dat_q   <= ack_d ? mem[rd_adr] : '0;
        end
    end

    // Preload port; RAM contents survive reset. Same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_adr] <= init_dat;
        end
    end

    assign ack_mem2cc = ack_q;
    assign dat_mem2cc = dat_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_refill_responder.sv
// Directed bench for mem_refill_responder: one instance with LATENCY=3, one with LATENCY=0,
// sharing clock, reset and the preload port.
module tb_mem_refill_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_we = 1'b0;
    logic [9:0]  init_adr = '0;
    logic [31:0] init_dat = '0;

    logic        req3 = 1'b0, req0 = 1'b0;
    logic [31:0] adr3 = '0, adr0 = '0;
    logic        ack3, ack0, busy3, busy0;
    logic [31:0] dat3, dat0;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_refill_responder #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_cc2mem(req3), .adr_cc2mem(adr3),
        .ack_mem2cc(ack3), .dat_mem2cc(dat3),
        .init_we(init_we), .init_adr(init_adr), .init_dat(init_dat), .busy(busy3)
    );

    mem_refill_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_cc2mem(req0), .adr_cc2mem(adr0),
        .ack_mem2cc(ack0), .dat_mem2cc(dat0),
        .init_we(init_we), .init_adr(init_adr), .init_dat(init_dat), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        init_we  = 1'b1;
        init_adr = a;
        init_dat = d;
        tick();
        init_we  = 1'b0;
    endtask

    // Drives one request (sel=1 -> LATENCY=0 instance) and checks every cycle of it.
    // Step j is the cycle observed after edge k+j, k being the accepting edge.
    // poke_j >= 0 fires one preload write at edge k+poke_j.
    task automatic run_burst(input bit sel, input logic [31:0] adr, input int lat,
                             input int hold, input int poke_j,
                             input logic [9:0] poke_adr, input logic [31:0] poke_dat,
                             input string name);
        logic        a;
        logic        b;
        logic [31:0] d;
        if (sel) begin req0 = 1'b1; adr0 = adr; end
        else     begin req3 = 1'b1; adr3 = adr; end
        for (int j = 0; j < 5 + lat + hold; j++) begin
            init_we  = (j == poke_j);
            init_adr = poke_adr;
            init_dat = poke_dat;
            tick();
            init_we  = 1'b0;
            a = sel ? ack0 : ack3;
            b = sel ? busy0 : busy3;
            d = sel ? dat0 : dat3;
            check($sformatf("%s busy j%0d", name, j), {31'd0, b}, 32'd1);
            if (j < 1 + lat || j >= 5 + lat) begin
                check($sformatf("%s ack_lo j%0d", name, j), {31'd0, a}, 32'd0);
                check($sformatf("%s dat_zero j%0d", name, j), d, 32'd0);
            end else begin
                check($sformatf("%s ack_hi j%0d", name, j), {31'd0, a}, 32'd1);
                check($sformatf("%s beat%0d", name, j - 1 - lat), d, exp_q.pop_front());
            end
        end
        if (sel) req0 = 1'b0;
        else     req3 = 1'b0;
        tick();
        check({name, " idle_busy"}, {31'd0, (sel ? busy0 : busy3)}, 32'd0);
        check({name, " idle_ack"}, {31'd0, (sel ? ack0 : ack3)}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst ack3", {31'd0, ack3}, 32'd0);
        check("rst dat3", dat3, 32'd0);
        check("rst busy3", {31'd0, busy3}, 32'd0);
        check("rst ack0", {31'd0, ack0}, 32'd0);
        check("rst busy0", {31'd0, busy0}, 32'd0);
        rst = 1'b1;
        tick();

        // 0xFF07BD08: bits [11:4] = 0xD0 -> line base word 0x340
        for (int i = 0; i < 4; i++) preload(10'h340 + 10'(i), 32'hA0 + 32'(i));
        // 0x00000010: bits [11:4] = 0x01 -> words 4..7
        for (int i = 0; i < 4; i++) preload(10'h004 + 10'(i), 32'h40 + 32'(i));
        // 0x00000080: bits [11:4] = 0x08 -> words 0x20..0x23
        for (int i = 0; i < 4; i++) preload(10'h020 + 10'(i), 32'hC0 + 32'(i));

        // Test 1: LATENCY=3, HOLD kept for 3 cycles while req stays high
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst(1'b0, 32'hFF07BD08, 3, 3, -1, '0, '0, "t1");

        // Test 2: LATENCY=0
        exp_q = '{32'h40, 32'h41, 32'h42, 32'h43};
        run_burst(1'b1, 32'h00000010, 0, 1, -1, '0, '0, "t2");

        // Test 3: drop req in the second WAIT cycle
        req3 = 1'b1; adr3 = 32'h00000D00;
        tick();
        tick();
        req3 = 1'b0;
        tick();
        check("t3 abort busy", {31'd0, busy3}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3 no_ack %0d", i), {31'd0, ack3}, 32'd0);
            tick();
        end
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst(1'b0, 32'h00000D00, 3, 1, -1, '0, '0, "t3_retry");

        // Test 4: reset while beat 2 is on the bus
        req3 = 1'b1; adr3 = 32'h00000010;
        for (int j = 0; j < 7; j++) tick();
        check("t4 beat2 ack", {31'd0, ack3}, 32'd1);
        check("t4 beat2 dat", dat3, 32'h42);
        rst = 1'b0;
        req3 = 1'b0;
        tick();
        check("t4 rst ack", {31'd0, ack3}, 32'd0);
        check("t4 rst dat", dat3, 32'd0);
        check("t4 rst busy", {31'd0, busy3}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4 no_beat %0d", i), {31'd0, ack3}, 32'd0);
        end
        exp_q = '{32'h40, 32'h41, 32'h42, 32'h43};
        run_burst(1'b0, 32'h00000010, 3, 1, -1, '0, '0, "t4_fresh");

        // Test 5a: write word 3 of the pending line during WAIT
        exp_q = '{32'hC0, 32'hC1, 32'hC2, 32'hDEADBEEF};
        run_burst(1'b0, 32'h00000080, 3, 1, 1, 10'h023, 32'hDEADBEEF, "t5a");
        // Test 5b: write word 0 on the edge that reads it -> old value returned
        exp_q = '{32'hC0, 32'hC1, 32'hC2, 32'hDEADBEEF};
        run_burst(1'b0, 32'h00000080, 3, 1, 4, 10'h020, 32'h12345678, "t5b");
        exp_q = '{32'h12345678, 32'hC1, 32'hC2, 32'hDEADBEEF};
        run_burst(1'b0, 32'h00000080, 3, 1, -1, '0, '0, "t5c");

        // Test 6: aliasing addresses; long HOLD shows no second burst
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst(1'b0, 32'hFFFFFD08, 3, 8, -1, '0, '0, "t6_hi");
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst(1'b0, 32'h00001D00, 3, 1, -1, '0, '0, "t6_lo");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
